// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative HI/LO multiply/divide unit that sits beside the EX stage.
//   MULT/MULTU use radix-2 shift-add and DIV/DIVU use restoring division.
//   Each cycle performs one bit step, so 32 steps plus one fix-up cycle.
//   Signed operations run on operand magnitudes. The FIX cycle applies the
//   sign correction and commits HI/LO.
//
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   start, op         launch request, accepted only in IDLE
//                     (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   srcA, srcB        rs/rt operands (multiplicand/dividend, multiplier/divisor)
//   hiWrite, loWrite  MTHI/MTLO strobes with data wdata, honoured only in IDLE
//   flush             cancels an in-flight operation without committing
//   hi, lo            committed HI/LO registers
//   busy              operation in flight (CALC or FIX)
//   done              one-cycle pulse after HI/LO commit
module mul_div_unit #(
    parameter int WIDTH     = 32,
    parameter int STEP_BITS = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             hiWrite,
    input  logic             loWrite,
    input  logic [WIDTH-1:0] wdata,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [STEP_BITS-1:0] LAST_STEP = STEP_BITS'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [STEP_BITS-1:0] cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic                 sign_a_q, sign_a_d;
    logic                 sign_b_q, sign_b_d;
    // acc: upper product half / partial remainder.
    // work: multiplier being consumed / dividend shifting out as quotient shifts in.
    // opb: multiplicand / divisor magnitude.
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     work_q, work_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    // Launch-time operand conditioning.
    logic             in_signed;
    logic             in_neg_a, in_neg_b;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign in_signed = ~op[0];
    assign in_neg_a  = in_signed & srcA[WIDTH-1];
    assign in_neg_b  = in_signed & srcB[WIDTH-1];
    assign abs_a     = in_neg_a ? (WIDTH'(0) - srcA) : srcA;
    assign abs_b     = in_neg_b ? (WIDTH'(0) - srcB) : srcB;

    // One multiply step: add the multiplicand when the multiplier LSB is set,
    // then shift {carry, acc, work} right by one.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_q} + (work_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});

    // One restoring-divide step. Bit WIDTH of the difference is the borrow
    // because the partial remainder always stays below the divisor.
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;
    assign div_shift = {acc_q, work_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};

    // Sign correction for the FIX cycle.
    logic                 fix_signed;
    logic                 fix_neg_res;
    logic [2*WIDTH-1:0]   prod_mag, prod_neg;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    assign fix_signed  = ~op_q[0];
    assign fix_neg_res = fix_signed & (sign_a_q ^ sign_b_q);
    assign prod_mag    = {acc_q, work_q};
    assign prod_neg    = (2*WIDTH)'(0) - prod_mag;
    assign quo_fix     = fix_neg_res ? (WIDTH'(0) - work_q) : work_q;
    // After 32 steps with a zero divisor the remainder is |srcA|. The same
    // dividend-sign correction therefore restores srcA for the divide-by-zero result.
    assign rem_fix     = (fix_signed & sign_a_q) ? (WIDTH'(0) - acc_q) : acc_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        acc_d    = acc_q;
        work_d   = work_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // A launch drops any MTHI/MTLO in the same cycle.
                    state_d  = S_CALC;
                    cnt_d    = '0;
                    op_d     = op;
                    sign_a_d = in_neg_a;
                    sign_b_d = in_neg_b;
                    acc_d    = '0;
                    work_d   = abs_a;
                    opb_d    = abs_b;
                    // Multiply consumes srcB bit by bit, so srcB sits in work.
                    if (!op[1]) begin
                        work_d = abs_b;
                        opb_d  = abs_a;
                    end
                end else begin
                    if (hiWrite) hi_d = wdata;
                    if (loWrite) lo_d = wdata;
                end
            end

            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (!op_q[1]) begin
                        acc_d  = mul_sum[WIDTH:1];
                        work_d = {mul_sum[0], work_q[WIDTH-1:1]};
                    end else if (!div_diff[WIDTH]) begin
                        acc_d  = div_diff[WIDTH-1:0];
                        work_d = {work_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d  = div_shift[WIDTH-1:0];
                        work_d = {work_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + STEP_BITS'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_d = S_FIX;
                    end
                end
            end

            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (!op_q[1]) begin
                        hi_d = fix_neg_res ? prod_neg[2*WIDTH-1:WIDTH] : prod_mag[2*WIDTH-1:WIDTH];
                        lo_d = fix_neg_res ? prod_neg[WIDTH-1:0]       : prod_mag[WIDTH-1:0];
                    end else if (opb_q == '0) begin
                        hi_d = rem_fix;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            acc_q    <= '0;
            work_q   <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            acc_q    <= acc_d;
            work_q   <= work_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative HI/LO multiply/divide unit for the pipelined CPU, sitting beside the EX stage.
- EX launches MULT/MULTU/DIV/DIVU and issues MTHI/MTLO writes; MFHI/MFLO read the hi/lo outputs.
- busy drives the hazard unit, which stalls any HI/LO-dependent instruction until the result is committed.
- Radix-2 shift-add multiply and restoring divide; one 32-bit step per cycle.

Parameters:
- WIDTH, 32, operand/HI/LO width (only 32 is verified)
- STEP_BITS, 6, counter width; must hold WIDTH

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  launch operation (sampled only in IDLE)
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- srcA  in  WIDTH  rs operand (multiplicand / dividend)
- srcB  in  WIDTH  rt operand (multiplier / divisor)
- hiWrite  in  1  MTHI strobe
- loWrite  in  1  MTLO strobe
- wdata  in  WIDTH  MTHI/MTLO data
- flush  in  1  cancel in-flight operation
- hi  out  WIDTH  committed HI register
- lo  out  WIDTH  committed LO register
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse when HI/LO commit

Behaviour:
- Reset: asynchronous, active-low. Clock is clk; reset is reset_n.
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
- Reset mid-operation aborts the operation; no partial result is committed.
- States:
  - IDLE: busy=0.
  - CALC: busy=1; counter counts 0..31.
  - FIX: busy=1; applies sign correction and commits HI/LO.
- Transitions:
  - IDLE→CALC on start.
  - CALC→FIX after 32 steps.
  - FIX→IDLE unconditionally.
  - flush in CALC or FIX → IDLE; nothing is committed and done=0.
- Launch in IDLE at edge E0:
  - Latch op and operand signs.
  - Latch |srcA| and |srcB| for signed ops; raw values for unsigned ops.
  - Clear the accumulator/remainder.
- Timing:
  - busy rises after E0.
  - CALC steps occur at E1..E32.
  - FIX commits at E33; after E33, hi/lo hold the result, done=1 for exactly one cycle and busy=0.
  - Latency from start to visible result is 33 cycles.
- Multiply:
  - Full 64-bit product; hi = product[63:32], lo = product[31:0].
  - Signed: negate the 64-bit magnitude when the operand signs differ.
- Divide:
  - lo = quotient, hi = remainder.
  - Signed: quotient is negated when the signs differ; remainder takes the sign of the dividend (truncation toward zero).
- Divide by zero (the divisor is checked in FIX after 32 steps; latency is unchanged): lo = 0xFFFFFFFF, hi = srcA.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- start while busy: ignored.
- hiWrite/loWrite:
  - In IDLE: write wdata at the next edge with no latency; both may assert together.
  - While busy: ignored.
- start and hiWrite/loWrite in the same IDLE cycle: start wins and the writes are dropped. The pipeline never issues this combination.
- done and start in the same cycle: done is from the finished op; start is accepted because the state is IDLE.
- hi/lo hold their value at all times except on commit, MTHI/MTLO or reset.

Test Plan:
- MULT 7 × 0xFFFFFFFD → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulses exactly once; busy high for 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV 0xFFFFFFF9 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 0x64 / 0x7 → lo=0x0E, hi=0x02.
- DIVU 0x64 / 0 → lo=0xFFFFFFFF, hi=0x64.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0x1234 then MTLO 0x5678 in IDLE → hi=0x1234, lo=0x5678 the next cycle.
- MULT launched, then during CALC: second start, MTLO 0xAA and flush at cycle 10 → busy drops, hi/lo stay 0x1234/0x5678, done is never asserted.
- Same MULT with reset_n pulsed low at cycle 20 → hi/lo/busy/done clear immediately (asynchronous); a new start after release produces a correct result.
